// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer: controller state encoding,
// PWM period/duty constants and the saturating step helper.
package pwm_pkg;

    localparam int         PWM_PERIOD = 255;
    localparam logic [7:0] PWM_MAX    = 8'hFF;
    localparam int         DUTY_W     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } fade_state_t;

    // Move cur toward tgt by at most step, landing exactly on tgt when the
    // remaining distance is no larger than step (never overshoots or wraps).
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] w_diff;
        logic [DUTY_W-1:0] w_res;
        w_res = tgt;
        if (tgt >= cur) begin
            w_diff = {1'b0, tgt} - {1'b0, cur};
            if (w_diff > {1'b0, step}) w_res = cur + step;
        end else begin
            w_diff = {1'b0, cur} - {1'b0, tgt};
            if (w_diff > {1'b0, step}) w_res = cur - step;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter (0..PERIOD-1) with a pulse on count 0.
// Reusable to phase-align several PWM channels to a common period.
module pwm_period_timer #(
    parameter int PERIOD = 255,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_period_start
);

    logic [CNT_W-1:0] r_count;

    // Period counter: advances only while enabled, wraps after PERIOD-1.
    // NOTE: asynchronous reset belongs in the sensitivity list; state updates use <= so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (r_count == CNT_W'(PERIOD - 1)) r_count <= '0;
            else                               r_count <= r_count + 1'b1;
        end
    end

    assign o_period_start = i_enable && (r_count == '0);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer driving the duty input of a pwm channel. Accepts
// (target, step, periods) commands over valid/ready and ramps pwmValue
// toward target one step every 'periods' PWM periods.
// Build option: define PWM_FADE_PREEMPT_EN to accept new commands while a
// ramp is in progress (the running ramp is abandoned without a done pulse).
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    input  logic [7:0]        cmd_periods,
    output logic [DUTY_W-1:0] pwmValue,
    output logic              period_start,
    output logic              busy,
    output logic              done
);

    fade_state_t       r_state;
    logic [DUTY_W-1:0] r_pwm;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_step;
    logic [7:0]        r_periods;
    logic [7:0]        r_div;
    logic              r_done;

    logic              w_period_start;
    logic              w_accept;
    logic [DUTY_W-1:0] w_step_eff;
    logic [7:0]        w_periods_eff;
    logic [DUTY_W-1:0] w_next_pwm;

    pwm_period_timer #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (enable),
        .o_period_start (w_period_start)
    );

`ifdef PWM_FADE_PREEMPT_EN
    assign cmd_ready = enable;
`else
    assign cmd_ready = enable && (r_state == ST_IDLE);
`endif

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_step_eff    = (cmd_step == '0)    ? DUTY_W'(1) : cmd_step;
    assign w_periods_eff = (cmd_periods == '0) ? 8'd1       : cmd_periods;
    assign w_next_pwm    = step_toward(r_pwm, r_target, r_step);

    // Command acceptance and period-aligned ramp stepping; everything holds while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pwm     <= '0;
            r_target  <= '0;
            r_step    <= '0;
            r_periods <= '0;
            r_div     <= '0;
            r_done    <= 1'b0;
        end else if (!enable) begin
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // A period_start coinciding with acceptance is deliberately ignored.
                r_target  <= cmd_target;
                r_step    <= w_step_eff;
                r_periods <= w_periods_eff;
                r_div     <= w_periods_eff;
                if (cmd_target == r_pwm) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= ST_RAMP;
                end
            end else if (r_state == ST_RAMP && w_period_start) begin
                if (r_div > 8'd1) begin
                    r_div <= r_div - 8'd1;
                end else begin
                    r_div <= r_periods;
                    r_pwm <= w_next_pwm;
                    if (w_next_pwm == r_target) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign pwmValue     = r_pwm;
    assign period_start = w_period_start;
    assign busy         = (r_state == ST_RAMP);
    assign done         = r_done && enable;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl. A reference model predicts, at
// command acceptance, the full schedule of duty values (with the enabled-cycle
// at which each becomes visible) and the done pulse; a monitor compares every
// observed pwmValue change and done pulse against that schedule, plus busy,
// cmd_ready and period_start every cycle.
module tb_pwm_fade_ctrl;

    localparam int P = 255;
`ifdef PWM_FADE_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, cmd_valid;
    logic [7:0] cmd_target, cmd_step, cmd_periods;
    logic       cmd_ready, period_start, busy, done;
    logic [7:0] pwmValue;

    pwm_fade_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_periods  (cmd_periods),
        .pwmValue     (pwmValue),
        .period_start (period_start),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int v; } ev_t;

    ev_t  exp_q[$];
    ev_t  sched[$];
    int   done_q[$];
    int   ecyc;
    int   m_duty;
    bit   m_busy;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not observed in time (t=%0t)", name, $time);
    endtask

    // Build the complete expected schedule for a command accepted in enabled cycle k.
    task automatic plan(input int k, input int tgt, input int st, input int per);
        int v, base, j, e;
        if (st == 0)  st = 1;
        if (per == 0) per = 1;
        while (exp_q.size() > 0 && exp_q[$].t > k) void'(exp_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > k) void'(done_q.pop_back());
        sched.delete();
        if (tgt == m_duty) begin
            done_q.push_back(k + 1);
            m_busy = 1'b0;
            return;
        end
        m_busy = 1'b1;
        v      = m_duty;
        base   = (k / P + 1) * P;   // first period start strictly after acceptance
        j      = 1;
        e      = base;
        while (v != tgt) begin
            if (tgt > v) v = (tgt - v <= st) ? tgt : v + st;
            else         v = (v - tgt <= st) ? tgt : v - st;
            e = base + (j * per - 1) * P;
            sched.push_back('{e + 1, v});
            exp_q.push_back('{e + 1, v});
            j++;
        end
        done_q.push_back(e + 1);
    endtask

    // Reference model, advanced on every enabled clock edge.
    initial begin
        ecyc = 0; m_duty = 0; m_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                ecyc = 0; m_duty = 0; m_busy = 1'b0;
                sched.delete(); exp_q.delete(); done_q.delete();
            end else if (enable) begin
                if (cmd_valid && (!m_busy || PRE))
                    plan(ecyc, cmd_target, cmd_step, cmd_periods);
                ecyc++;
                if (sched.size() > 0 && sched[0].t == ecyc) begin
                    m_duty = sched[0].v;
                    void'(sched.pop_front());
                    if (sched.size() == 0) m_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: sample outputs mid-cycle and compare against the model.
    initial begin
        logic [7:0] last_pv;
        ev_t        ev;
        int         dt;
        last_pv = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_pv = 8'd0;
            end else begin
                if (pwmValue !== last_pv) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pwm_change", pwmValue, last_pv);
                    end else begin
                        ev = exp_q.pop_front();
                        check("pwm_value", pwmValue, ev.v);
                        check("pwm_time", ecyc, ev.t);
                    end
                    last_pv = pwmValue;
                end
                while (exp_q.size() > 0 && exp_q[0].t < ecyc) begin
                    void'(exp_q.pop_front());
                    fail("pwm_missed_step");
                end
                if (done === 1'b1) begin
                    if (done_q.size() == 0) begin
                        check("spurious_done", done, 0);
                    end else begin
                        dt = done_q.pop_front();
                        check("done_time", ecyc, dt);
                    end
                end
                while (done_q.size() > 0 && done_q[0] < ecyc) begin
                    void'(done_q.pop_front());
                    fail("done_missing");
                end
                check("busy", busy, m_busy);
                check("cmd_ready", cmd_ready, enable && (!m_busy || PRE));
                check("period_start", period_start, enable && (ecyc % P == 0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int t, input int s, input int p);
        cmd_target  = 8'(t);
        cmd_step    = 8'(s);
        cmd_periods = 8'(p);
        cmd_valid   = 1'b1;
        tick(1);
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (!m_busy && exp_q.size() == 0 && done_q.size() == 0) break;
            tick(1);
        end
        if (i == bound) fail("wait_idle_timeout");
        tick(2);
    endtask

    initial begin
        int held, t, s, p, i;
        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0;
        cmd_target = 8'd0; cmd_step = 8'd0; cmd_periods = 8'd0;
        tick(3);
        reset = 1'b0;
        check("reset_pwm", pwmValue, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", cmd_ready, 1);

        // Basic up-ramp, down-ramp, clamped ramp with periods=2.
        send(200, 50, 1);  wait_idle(3000); check("ramp_up_final", pwmValue, 200);
        send(0, 64, 1);    wait_idle(3000); check("ramp_down_final", pwmValue, 0);
        send(130, 50, 2);  wait_idle(5000); check("ramp_clamp_final", pwmValue, 130);

        // Target equal to current duty: immediate done, no ramp.
        send(130, 9, 3);
        check("equal_done", done, 1);
        check("equal_busy", busy, 0);
        tick(1);
        check("equal_done_clear", done, 0);
        check("equal_pwm", pwmValue, 130);
        wait_idle(100);

        // Freeze mid-ramp with enable low.
        send(0, 20, 1);
        tick(300);
        enable = 1'b0;
        held   = pwmValue;
        tick(1000);
        check("frozen_pwm", pwmValue, held);
        check("frozen_busy", busy, 1);
        check("frozen_ready", cmd_ready, 0);
        enable = 1'b1;
        wait_idle(5000);
        check("resume_final", pwmValue, 0);

        // Second command during a ramp: preempts or is ignored depending on build.
        send(200, 50, 1);
        for (i = 0; i < 2000 && m_duty != 100; i++) tick(1);
        if (i == 2000) fail("reach_100_timeout");
        check("preempt_point_ready", cmd_ready, PRE);
        send(20, 40, 1);
        wait_idle(3000);
        check("preempt_final", pwmValue, PRE ? 20 : 200);

        // Step and periods of zero behave as one.
        t = (m_duty <= 252) ? m_duty + 3 : m_duty - 3;
        send(t, 0, 0);
        wait_idle(2000);
        check("zero_step_final", pwmValue, t);

        // Randomized commands.
        repeat (5) begin
            t = $urandom_range(0, 255);
            s = $urandom_range(40, 120);
            p = $urandom_range(0, 2);
            send(t, s, p);
            wait_idle(8000);
            check("random_final", pwmValue, t);
        end

        // Reset in the middle of a ramp.
        send((m_duty > 128) ? 0 : 255, 5, 1);
        tick(700);
        reset = 1'b1;
        #1;
        check("midreset_pwm", pwmValue, 0);
        check("midreset_busy", busy, 0);
        tick(2);
        reset = 1'b0;
        check("postreset_ready", cmd_ready, 1);
        check("postreset_pwm", pwmValue, 0);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
